dsp_mac_pipe: RTL and testbench

- Parametrised successor to the team's single-shot pre-add/multiply/compare DSP slice.
- Three-stage pipelined signed datapath: pre-adder (A±D), multiplier (×B), post-adder/accumulator (+C or +ACC).
- Adds per-beat pattern detect, overflow flag and valid/ready flow control.
- Sits between the operand-fetch stage and the result stream in the arithmetic cluster.

---
 rtl/dsp_mac_pkg.sv | 24 ++
 rtl/dsp_preadd_mul.sv | 77 +++++++
 rtl/dsp_mac_pipe.sv | 107 ++++++++++
 tb/tb_dsp_mac_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared types for the pipelined pre-add / multiply / accumulate slice.
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,  // (A+D)*B
    MODE_SUB  = 2'b01,  // (A-D)*B
    MODE_ADDC = 2'b10,  // (A+D)*B + C
    MODE_ACC  = 2'b11   // ACC + (A+D)*B
  } mode_e;

  // Result width: full product (2*DW+1) plus accumulator guard bits.
  function automatic int pw_f(input int dw, input int gw);
    return 2 * dw + 1 + gw;
  endfunction

  // Control payload travelling with every beat. The parameter-dependent
  // fields (c, data) ride next to it as plain vectors in each stage.
  typedef struct packed {
    logic  vld;
    mode_e mode;
    logic  acc_clr;
  } stage_ctl_t;

endpackage

// File: rtl/dsp_preadd_mul.sv
// Operand capture, pre-adder (S1) and multiplier (S2) of the MAC pipe.
// All registers advance together on i_en so a stall freezes the front end.
module dsp_preadd_mul
  import dsp_mac_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_vld,
  input  logic [1:0]           i_mode,
  input  logic                 i_acc_clr,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  input  logic signed [DW-1:0] i_c,
  input  logic signed [DW-1:0] i_d,
  output stage_ctl_t           o_ctl,
  output logic signed [DW-1:0] o_c,
  output logic signed [2*DW:0] o_prod
);

  stage_ctl_t            r_in_ctl, r_s1_ctl, r_s2_ctl;
  logic signed [DW-1:0]  r_in_a, r_in_b, r_in_c, r_in_d;
  logic signed [DW-1:0]  r_s1_b, r_s1_c, r_s2_c;
  logic signed [DW:0]    r_s1_pre;
  logic signed [2*DW:0]  r_s2_prod;

  logic signed [DW:0]    w_a_ext, w_d_ext, w_pre;
  logic signed [2*DW:0]  w_pre_ext, w_b_ext, w_prod;

  // One extra bit on the pre-adder keeps A+-D exact (e.g. -128-127).
  assign w_a_ext = {r_in_a[DW-1], r_in_a};
  assign w_d_ext = {r_in_d[DW-1], r_in_d};
  assign w_pre   = (r_in_ctl.mode == MODE_SUB) ? (w_a_ext - w_d_ext) : (w_a_ext + w_d_ext);

  // Both factors widened to the product width so the multiply is exact.
  assign w_pre_ext = {{DW{r_s1_pre[DW]}}, r_s1_pre};
  assign w_b_ext   = {{(DW+1){r_s1_b[DW-1]}}, r_s1_b};
  assign w_prod    = w_pre_ext * w_b_ext;

  // Operand capture, pre-add and multiply registers, all gated by the pipe enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ctl  <= '0;
      r_in_a    <= '0;
      r_in_b    <= '0;
      r_in_c    <= '0;
      r_in_d    <= '0;
      r_s1_ctl  <= '0;
      r_s1_pre  <= '0;
      r_s1_b    <= '0;
      r_s1_c    <= '0;
      r_s2_ctl  <= '0;
      r_s2_prod <= '0;
      r_s2_c    <= '0;
    end else if (i_en) begin
      r_in_ctl  <= '{vld: i_vld, mode: mode_e'(i_mode), acc_clr: i_acc_clr};
      r_in_a    <= i_a;
      r_in_b    <= i_b;
      r_in_c    <= i_c;
      r_in_d    <= i_d;
      r_s1_ctl  <= r_in_ctl;
      r_s1_pre  <= w_pre;
      r_s1_b    <= r_in_b;
      r_s1_c    <= r_in_c;
      r_s2_ctl  <= r_s1_ctl;
      r_s2_prod <= w_prod;
      r_s2_c    <= r_s1_c;
    end
  end

  assign o_ctl  = r_s2_ctl;
  assign o_c    = r_s2_c;
  assign o_prod = r_s2_prod;

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed pre-add / multiply / post-add-or-accumulate slice with
// pattern detect, overflow flag and valid/ready flow control.
// Optional build macro DSP_MAC_SAT_EN: clamp result and ACC on overflow
// instead of wrapping.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int DW = 8,
  parameter int GW = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic signed [DW-1:0]             a,
  input  logic signed [DW-1:0]             b,
  input  logic signed [DW-1:0]             c,
  input  logic signed [DW-1:0]             d,
  input  logic [1:0]                       mode,
  input  logic                             acc_clr,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic signed [pw_f(DW, GW)-1:0]   m_tdata,
  output logic                             pat_det,
  output logic                             overflow
);

  localparam int PW = pw_f(DW, GW);
  localparam int QW = 2 * DW + 1;

  logic                 w_en;
  stage_ctl_t           w_s2_ctl;
  logic signed [DW-1:0] w_s2_c;
  logic signed [QW-1:0] w_s2_prod;
  logic signed [PW-1:0] w_c_pw, w_res;
  logic signed [PW:0]   w_prod_ext, w_c_ext, w_acc_ext, w_sum;
  logic                 w_ovf, w_pat;
  logic signed [PW-1:0] r_acc;

  // Single global enable: the whole pipe moves unless the output is blocked.
  assign w_en    = !m_valid || m_ready;
  assign s_ready = w_en;

  dsp_preadd_mul #(.DW(DW)) u_front (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_en),
    .i_vld     (s_valid),
    .i_mode    (mode),
    .i_acc_clr (acc_clr),
    .i_a       (a),
    .i_b       (b),
    .i_c       (c),
    .i_d       (d),
    .o_ctl     (w_s2_ctl),
    .o_c       (w_s2_c),
    .o_prod    (w_s2_prod)
  );

  // Everything is summed one bit wider than the result so overflow is exact.
  assign w_c_pw     = {{(PW-DW){w_s2_c[DW-1]}}, w_s2_c};
  assign w_c_ext    = {w_c_pw[PW-1], w_c_pw};
  assign w_prod_ext = {{(PW+1-QW){w_s2_prod[QW-1]}}, w_s2_prod};
  assign w_acc_ext  = w_s2_ctl.acc_clr ? '0 : {r_acc[PW-1], r_acc};

  // S3 post-adder: plain product, product plus C, or accumulate.
  always_comb begin
    w_sum = w_prod_ext;
    case (w_s2_ctl.mode)
      MODE_ADDC: w_sum = w_prod_ext + w_c_ext;
      MODE_ACC:  w_sum = w_acc_ext + w_prod_ext;
      default:   w_sum = w_prod_ext;
    endcase
  end

  assign w_ovf = w_sum[PW] ^ w_sum[PW-1];

`ifdef DSP_MAC_SAT_EN
  assign w_res = !w_ovf ? w_sum[PW-1:0] :
                 (w_sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}});
`else
  assign w_res = w_sum[PW-1:0];
`endif

  assign w_pat = (w_s2_ctl.mode == MODE_ADDC) ? (w_res == '0) : (w_res == w_c_pw);

  // Output register and accumulator; ACC is both read and written here, so
  // back-to-back accumulate beats chain without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid  <= 1'b0;
      m_tdata  <= '0;
      pat_det  <= 1'b0;
      overflow <= 1'b0;
      r_acc    <= '0;
    end else if (w_en) begin
      m_valid <= w_s2_ctl.vld;
      if (w_s2_ctl.vld) begin
        m_tdata  <= w_res;
        pat_det  <= w_pat;
        overflow <= w_ovf;
        if (w_s2_ctl.mode == MODE_ACC) r_acc <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe (DW=8, GW=4, PW=21).
module tb_dsp_mac_pipe;

  localparam int     DW  = 8;
  localparam int     PW  = 21;
  localparam longint LIM = longint'(1) << (PW - 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [DW-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [1:0]           mode = 2'b00;
  logic                 acc_clr = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b1;
  logic signed [PW-1:0] m_tdata;
  logic                 pat_det, overflow;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  typedef struct {
    longint data;
    bit     pat;
    bit     ovf;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  longint acc_m = 0;
  bit     held_v = 0;
  longint held_d;
  bit     held_p, held_o;

  dsp_mac_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .mode     (mode),
    .acc_clr  (acc_clr),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_tdata  (m_tdata),
    .pat_det  (pat_det),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: exact integer arithmetic on the beat, then wrap or clamp.
  function automatic exp_t model(input int md, input int ai, input int bi,
                                 input int ci, input int di, input bit clr);
    longint pre, prod, sum, res;
    exp_t   e;
    pre  = (md == 1) ? longint'(ai - di) : longint'(ai + di);
    prod = pre * bi;
    case (md)
      2:       sum = prod + ci;
      3:       sum = (clr ? 0 : acc_m) + prod;
      default: sum = prod;
    endcase
    e.ovf = (sum > LIM - 1) || (sum < -LIM);
`ifdef DSP_MAC_SAT_EN
    res = (sum > LIM - 1) ? LIM - 1 : ((sum < -LIM) ? -LIM : sum);
`else
    res = sum;
    while (res > LIM - 1) res -= 2 * LIM;
    while (res < -LIM) res += 2 * LIM;
`endif
    if (md == 3) acc_m = res;
    e.data = res;
    e.pat  = (md == 2) ? (res == 0) : (res == ci);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int md, input int ai, input int bi, input int ci,
                      input int di, input bit clr);
    int n = 0;
    mode = 2'(md); a = 8'(ai); b = 8'(bi); c = 8'(ci); d = 8'(di);
    acc_clr = clr; s_valid = 1'b1;
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("send_timeout", 0, 1);
    else sb.push_back(model(md, ai, bi, ci, di, clr));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic expect_next(input string nm, input longint ed, input bit ep, input bit eo);
    int n = 0;
    while (!(m_valid && m_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, longint'(m_valid), 1);
    chk({nm, "_data"}, longint'($signed(m_tdata)), ed);
    chk({nm, "_pat"}, longint'(pat_det), longint'(ep));
    chk({nm, "_ovf"}, longint'(overflow), longint'(eo));
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", longint'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Downstream ready pattern, changed just after the rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on each transfer and checks stall behaviour.
  always @(negedge clk) begin
    if (!rst) begin
      held_v = 0;
    end else begin
      if (m_valid && !m_ready) begin
        chk("s_ready_stall", longint'(s_ready), 0);
        if (held_v) begin
          chk("hold_data", longint'($signed(m_tdata)), held_d);
          chk("hold_pat", longint'(pat_det), longint'(held_p));
          chk("hold_ovf", longint'(overflow), longint'(held_o));
        end
        held_v = 1;
        held_d = $signed(m_tdata);
        held_p = pat_det;
        held_o = overflow;
      end else begin
        held_v = 0;
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_data", longint'($signed(m_tdata)), mon_e.data);
          chk("sb_pat", longint'(pat_det), longint'(mon_e.pat));
          chk("sb_ovf", longint'(overflow), longint'(mon_e.ovf));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_m_valid", longint'(m_valid), 0);
    chk("rst_m_tdata", longint'($signed(m_tdata)), 0);
    chk("rst_pat", longint'(pat_det), 0);
    chk("rst_ovf", longint'(overflow), 0);
    chk("rst_s_ready", longint'(s_ready), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // mode 00 with latency measurement
    send(0, 3, 5, 35, 4, 0);
    chk("lat_n0", longint'(m_valid), 0);
    @(negedge clk); chk("lat_n1", longint'(m_valid), 0);
    @(negedge clk); chk("lat_n2", longint'(m_valid), 0);
    @(negedge clk); chk("lat_n3", longint'(m_valid), 1);
    expect_next("m00", 35, 1, 0);

    send(1, -128, 127, 0, 127, 0);
    expect_next("m01", -32385, 0, 0);
    send(2, 10, -3, 100, -2, 0);
    expect_next("m10", 76, 0, 0);
    send(2, 0, 0, 0, 0, 0);
    expect_next("m10_zero", 0, 1, 0);

    // accumulate chain: 30 back-to-back beats, then beats 31..33 one at a time
    for (int i = 1; i <= 30; i++) send(3, -128, -128, 0, -128, i == 1);
    drain();
    send(3, -128, -128, 0, -128, 0);
    expect_next("acc31", 1015808, 0, 0);
    send(3, -128, -128, 0, -128, 0);
`ifdef DSP_MAC_SAT_EN
    expect_next("acc32", 1048575, 0, 1);
`else
    expect_next("acc32", -1048576, 0, 1);
`endif
    send(3, -128, -128, 0, -128, 1);
    expect_next("acc33", 32768, 0, 0);

    // mid-stream stall
    fork
      for (int i = 0; i < 8; i++) send(0, i + 1, 2 - i, $urandom_range(0, 20), i, 0);
      begin
        repeat (5) @(negedge clk);
        rdy_mode = 2;
        repeat (6) @(negedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    // asynchronous reset with beats in flight and ACC = 32768
    send(3, -128, -128, 0, -128, 1);
    expect_next("pre_rst_acc", 32768, 0, 0);
    send(0, 1, 1, 0, 1, 0);
    send(0, 2, 2, 0, 2, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", longint'(m_valid), 1);
    #1;
    rst = 1'b0;
    sb.delete();
    acc_m = 0;
    #1;
    chk("async_rst_valid", longint'(m_valid), 0);
    chk("async_rst_data", longint'($signed(m_tdata)), 0);
    chk("async_rst_pat", longint'(pat_det), 0);
    chk("async_rst_ovf", longint'(overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", longint'(m_valid), 0);
    send(3, -128, -128, 0, -128, 0);
    expect_next("post_rst_acc", 32768, 0, 0);

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int md;
      md = int'($urandom_range(0, 3));
      send(md, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rdy_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
